// File: rtl/core_pipe_pkg.sv
// rtl/core_pipe_pkg.sv - shared types and constants for the fetch/decode pipeline register
package core_pipe_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline entry with valid bit, load/clear and async reset
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // clear drops only the valid bit so the last payload stays visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - fetch-to-decode register with skid buffer, flush and NOP bubbles
module if_id_skid_reg #(
    parameter int          XLEN      = core_pipe_pkg::XLEN,
    parameter int          ILEN      = core_pipe_pkg::ILEN,
    parameter logic [ILEN-1:0] NOP_INSTR = core_pipe_pkg::NOP_INSTR,
    parameter int          PC_INC    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [ILEN-1:0] out_instr
);
    import core_pipe_pkg::*;

    localparam int W = XLEN + ILEN;

    skid_state_t    state, state_n;
    logic           accept, consume;
    logic           main_load, main_clear, skid_load, skid_clear;
    logic [W-1:0]   main_d, main_q, skid_q;
    logic           main_valid, skid_valid;

    pipe_slot #(.W(W)) u_main (
        .clk(clk), .rst_n(rst_n), .load(main_load), .clear(main_clear),
        .d(main_d), .valid(main_valid), .q(main_q)
    );

    pipe_slot #(.W(W)) u_skid (
        .clk(clk), .rst_n(rst_n), .load(skid_load), .clear(skid_clear),
        .d({in_pc, in_instr}), .valid(skid_valid), .q(skid_q)
    );

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

    always_comb begin
        state_n    = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = {in_pc, in_instr};
        if (flush) begin
            state_n    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_load = 1'b1;
                    state_n   = BUSY;
                end
                BUSY: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_n   = FULL;
                    end else if (consume) begin
                        main_clear = 1'b1;
                        state_n    = EMPTY;
                    end
                end
                FULL: if (consume && skid_valid) begin
                    main_d     = skid_q;
                    main_load  = 1'b1;
                    skid_clear = 1'b1;
                    state_n    = BUSY;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // in_ready is a flop so decode backpressure never reaches fetch combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != FULL);
        end
    end

    assign out_valid    = main_valid;
    assign out_pc       = main_q[W-1:ILEN];
    assign out_pc_plus4 = out_pc + XLEN'(PC_INC);
    assign out_instr    = main_valid ? main_q[ILEN-1:0] : NOP_INSTR;

endmodule
